// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - serial config deserializer and comb_set sequencer for one lut
module lut_config_loader #(
  parameter int INPUTS     = 4,
  parameter int MEM_SIZE   = 2**INPUTS,
  parameter int SET_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic                cfg_bit,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [MEM_SIZE-1:0] config_out,
  output logic                comb_set,
  output logic                done,
  output logic                scan_out
);

  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam int SW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t              state;
  logic [MEM_SIZE-1:0] sr;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       set_cnt;
  logic [MEM_SIZE-1:0] next_word;

  assign next_word = {sr[MEM_SIZE-2:0], cfg_bit};
  assign scan_out  = sr[MEM_SIZE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      set_cnt    <= '0;
      config_out <= '0;
      cfg_ready  <= 1'b0;
      comb_set   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_en) begin
            state     <= SHIFT;
            cnt       <= '0;
            cfg_ready <= 1'b1;
          end
        end
        SHIFT: begin
          // Abort wins over a same-edge accept so a partial word never reaches the lut.
          if (!cfg_en) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_ready <= 1'b0;
          end else if (cfg_valid) begin
            sr  <= next_word;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(MEM_SIZE - 1)) begin
              config_out <= next_word;
              state      <= COMMIT;
              cfg_ready  <= 1'b0;
              comb_set   <= 1'b1;
              set_cnt    <= '0;
            end
          end
        end
        COMMIT: begin
          if (set_cnt == SW'(SET_CYCLES - 1)) begin
            comb_set <= 1'b0;
            if (cfg_en) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            set_cnt <= set_cnt + SW'(1);
          end
        end
        DONE: begin
          if (!cfg_en) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// tb/tb_lut_config_loader.sv - directed bench for lut_config_loader (single, long-commit and chained instances)
module tb_lut_config_loader;

  logic clk = 1'b0;
  logic rst_n, cfg_en, cfg_bit, cfg_valid;
  logic c1_ready, c1_set, c1_done, c1_scan;
  logic c3_ready, c3_set, c3_done, c3_scan;
  logic cb_ready, cb_set, cb_done, cb_scan;
  logic [15:0] c1_cfg, c3_cfg, cb_cfg;
  logic [15:0] sr_a, sr_b, w;
  int checks = 0;
  int errors = 0;
  int set_hits;

  always #5 clk = ~clk;

  lut_config_loader #(.INPUTS(4), .SET_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(c1_ready), .config_out(c1_cfg), .comb_set(c1_set), .done(c1_done), .scan_out(c1_scan));

  lut_config_loader #(.INPUTS(4), .SET_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(c3_ready), .config_out(c3_cfg), .comb_set(c3_set), .done(c3_done), .scan_out(c3_scan));

  lut_config_loader #(.INPUTS(4), .SET_CYCLES(1)) dutb (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_bit(c1_scan), .cfg_valid(cfg_valid),
    .cfg_ready(cb_ready), .config_out(cb_cfg), .comb_set(cb_set), .done(cb_done), .scan_out(cb_scan));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] word, input bit gaps);
    set_hits = 0;
    for (int i = 15; i >= 0; i--) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        cfg_bit   = ~word[i];
        repeat ((i % 4 == 1) ? 3 : 1) begin
          tick;
          if (c1_set) set_hits++;
        end
      end
      cfg_valid = 1'b1;
      cfg_bit   = word[i];
      tick;
      if (i != 0 && c1_set) set_hits++;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic idle_wait;
    cfg_en = 1'b0;
    repeat (4) tick;
  endtask

  initial begin
    rst_n = 1'b1; cfg_en = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick;
    check("rst_ready", c1_ready, 0);
    check("rst_set", c1_set, 0);
    check("rst_done", c1_done, 0);
    check("rst_cfg", c1_cfg, 0);
    check("rst_scan", c1_scan, 0);
    rst_n = 1'b1;

    // T1: continuous stream
    cfg_en = 1'b1;
    tick;
    check("t1_ready_shift", c1_ready, 1);
    send_word(16'hA5C3, 1'b0);
    check("t1_early_set", set_hits, 0);
    check("t1_set", c1_set, 1);
    check("t1_cfg", c1_cfg, 16'hA5C3);
    check("t1_ready_commit", c1_ready, 0);
    tick;
    check("t1_set_one_cycle", c1_set, 0);
    check("t1_done", c1_done, 1);
    check("t1_ready_done", c1_ready, 0);
    cfg_valid = 1'b1;
    tick;
    check("t1_done_hold", c1_done, 1);
    check("t1_no_restart", c1_ready, 0);
    cfg_valid = 1'b0;
    idle_wait;
    check("t1_done_clear", c1_done, 0);

    // T2: gapped stream
    cfg_en = 1'b1;
    tick;
    send_word(16'hA5C3, 1'b1);
    check("t2_early_set", set_hits, 0);
    check("t2_set", c1_set, 1);
    check("t2_cfg", c1_cfg, 16'hA5C3);
    idle_wait;

    // T3: abort leaves config_out untouched
    cfg_en = 1'b1;
    tick;
    send_word(16'h1234, 1'b0);
    check("t3_cfg_load", c1_cfg, 16'h1234);
    idle_wait;
    cfg_en = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick;
    end
    cfg_en = 1'b0;
    tick;
    check("t3_abort_ready", c1_ready, 0);
    check("t3_abort_set", c1_set, 0);
    cfg_valid = 1'b0;
    tick;
    check("t3_abort_set2", c1_set, 0);
    check("t3_abort_cfg", c1_cfg, 16'h1234);
    cfg_en = 1'b1;
    tick;
    send_word(16'h00FF, 1'b0);
    check("t3_reload_cfg", c1_cfg, 16'h00FF);
    check("t3_reload_set", c1_set, 1);
    idle_wait;

    // T4a: reset mid-SHIFT after 9 bits
    cfg_en = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick;
    end
    check("t4_scan_pre", c1_scan, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_shift_ready", c1_ready, 0);
    check("t4_shift_cfg", c1_cfg, 0);
    check("t4_shift_scan", c1_scan, 0);
    check("t4_shift_done", c1_done, 0);
    cfg_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick;
    send_word(16'hBEEF, 1'b0);
    check("t4_reload_cfg", c1_cfg, 16'hBEEF);
    check("t4_reload_set", c1_set, 1);
    idle_wait;

    // T4b: reset mid-COMMIT on the 3-cycle instance
    cfg_en = 1'b1;
    tick;
    send_word(16'h1234, 1'b0);
    check("t4c_set1", c3_set, 1);
    tick;
    check("t4c_set2", c3_set, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4c_set_drop", c3_set, 0);
    check("t4c_cfg", c3_cfg, 0);
    check("t4c_done", c3_done, 0);
    check("t4c_ready", c3_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick;
    send_word(16'hBEEF, 1'b0);
    check("t4c_reload_cfg", c3_cfg, 16'hBEEF);
    idle_wait;

    // T5: long commit survives cfg_en drop and stray cfg_valid
    cfg_en = 1'b1;
    tick;
    send_word(16'h8001, 1'b0);
    check("t5_set1", c3_set, 1);
    check("t5_cfg1", c3_cfg, 16'h8001);
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    tick;
    check("t5_set2", c3_set, 1);
    cfg_en = 1'b0;
    tick;
    check("t5_set3", c3_set, 1);
    check("t5_cfg3", c3_cfg, 16'h8001);
    tick;
    check("t5_set_end", c3_set, 0);
    check("t5_idle_done", c3_done, 0);
    check("t5_scan_kept", c3_scan, 1);
    check("t5_cfg_end", c3_cfg, 16'h8001);
    cfg_valid = 1'b0;
    tick;
    check("t5_idle_ready", c3_ready, 0);

    // T6: daisy chain against a reference shift model
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    sr_a = '0; sr_b = '0;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 16'h1357 : 16'h2468;
      cfg_en = 1'b1;
      tick;
      for (int i = 15; i >= 0; i--) begin
        cfg_valid = 1'b1; cfg_bit = w[i];
        check("t6_scan_a", c1_scan, sr_a[15]);
        check("t6_scan_b", cb_scan, sr_b[15]);
        tick;
        sr_b = {sr_b[14:0], sr_a[15]};
        sr_a = {sr_a[14:0], w[i]};
      end
      cfg_valid = 1'b0;
      check("t6_cfg_a", c1_cfg, sr_a);
      check("t6_cfg_b", cb_cfg, sr_b);
      check("t6_set_b", cb_set, 1);
      idle_wait;
    end
    check("t6_b_holds_a", cb_cfg, 16'h1357);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
